// File: rtl/mux_16to1.sv
// Single-bit 16-to-1 selector with a combinational output plus registered
// copies of the selected bit and the select value for downstream timing.
module mux_16to1 (
  output logic        Out,
  input  logic [15:0] In,
  input  logic [3:0]  Sel,
  input  logic        clk,
  input  logic        rst,
  output logic        Out_q,
  output logic [3:0]  Sel_q
);

  // 4:1 leaf; an unknown select matches no item, so simulation yields X
  // instead of quietly picking input 0.
  function automatic logic mux4(input logic [3:0] d, input logic [1:0] s);
    logic r;
    case (s)
      2'd0:    r = d[0];
      2'd1:    r = d[1];
      2'd2:    r = d[2];
      2'd3:    r = d[3];
      default: r = 1'bx;
    endcase
    return r;
  endfunction

  logic [3:0] stage1;

  // First level resolves Sel[1:0] within each nibble, second level picks the nibble.
  always_comb begin
    stage1    = '0;
    stage1[0] = mux4(In[3:0],   Sel[1:0]);
    stage1[1] = mux4(In[7:4],   Sel[1:0]);
    stage1[2] = mux4(In[11:8],  Sel[1:0]);
    stage1[3] = mux4(In[15:12], Sel[1:0]);
  end

  always_comb begin
    Out = mux4(stage1, Sel[3:2]);
  end

  // Registered copies only; nothing here feeds back into Out.
  always_ff @(posedge clk) begin
    if (rst) begin
      Out_q <= 1'b0;
      Sel_q <= 4'd0;
    end else begin
      Out_q <= Out;
      Sel_q <= Sel;
    end
  end

endmodule

// File: tb/tb_mux_16to1.sv
// Directed and randomized bench for mux_16to1 against a shift-based
// reference of the selected bit and a one-edge-delayed register model.
module tb_mux_16to1;

  logic        clk;
  logic        rst;
  logic        Out;
  logic [15:0] In;
  logic [3:0]  Sel;
  logic        Out_q;
  logic [3:0]  Sel_q;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  logic       exp_oq;
  logic [3:0] exp_sq;

  mux_16to1 dut (
    .Out   (Out),
    .In    (In),
    .Sel   (Sel),
    .clk   (clk),
    .rst   (rst),
    .Out_q (Out_q),
    .Sel_q (Sel_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: selected bit is bit number Sel of In
  function automatic logic ref_bit(input logic [15:0] d, input logic [3:0] s);
    logic [15:0] sh;
    sh = d >> s;
    return sh[0];
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clocked step: apply inputs away from the edge, confirm the
  // registers still hold the old value, then confirm capture after the edge.
  task automatic step(input logic [15:0] in_v, input logic [3:0] sel_v, input logic rst_v);
    @(negedge clk);
    In  = in_v;
    Sel = sel_v;
    rst = rst_v;
    #1;
    check("step_out", {3'b0, Out}, {3'b0, ref_bit(in_v, sel_v)});
    check("hold_out_q", {3'b0, Out_q}, {3'b0, exp_oq});
    check("hold_sel_q", Sel_q, exp_sq);
    @(posedge clk);
    #1;
    exp_oq = rst_v ? 1'b0 : ref_bit(in_v, sel_v);
    exp_sq = rst_v ? 4'd0 : sel_v;
    check("cap_out_q", {3'b0, Out_q}, {3'b0, exp_oq});
    check("cap_sel_q", Sel_q, exp_sq);
  endtask

  initial begin
    logic [15:0] pat;
    logic [15:0] r;

    // reset for two edges with all-ones input
    rst = 1'b1;
    In  = 16'hFFFF;
    Sel = 4'd9;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_q", {3'b0, Out_q}, 4'd0);
    check("rst_sel_q", Sel_q, 4'd0);
    check("rst_out", {3'b0, Out}, 4'd1);
    exp_oq = 1'b0;
    exp_sq = 4'd0;

    // select sweep over a fixed pattern
    pat = 16'b1111000011110000;
    In  = pat;
    for (int s = 0; s < 16; s++) begin
      Sel = 4'(s);
      #5;
      check("sweep", {3'b0, Out}, {3'b0, ((s / 4) % 2 == 1) ? 1'b1 : 1'b0});
    end

    // walking one against every select
    for (int k = 0; k < 16; k++) begin
      In = 16'd1 << k;
      for (int s = 0; s < 16; s++) begin
        Sel = 4'(s);
        #1;
        check("walk1", {3'b0, Out}, {3'b0, (s == k) ? 1'b1 : 1'b0});
      end
    end

    // Sel fixed at 7; only In[7] matters
    Sel = 4'd7;
    for (int i = 0; i < 12; i++) begin
      r    = 16'($urandom);
      r[7] = (i % 3 == 1);
      In   = r;
      #1;
      check("track7", {3'b0, Out}, {3'b0, (i % 3 == 1) ? 1'b1 : 1'b0});
    end

    // reset still held from the start: registers stay zero
    step(16'hFFFF, 4'd9, 1'b1);
    // release and capture
    step(pat, 4'd12, 1'b0);
    step(16'h0F0F, 4'd3, 1'b0);
    // single-edge reset mid-sequence, then resume
    step(16'hFFFF, 4'd10, 1'b1);
    step(16'hA5A5, 4'd5, 1'b0);
    step(16'hA5A5, 4'd1, 1'b0);

    // randomized sequence with occasional reset
    for (int i = 0; i < 60; i++) begin
      step(16'($urandom), 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
